// File: rtl/fb_arbiter_pkg.sv
// Shared frame-buffer types: geometry, pixel colours and read-return ownership tags.
package fb_arbiter_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_ADDR_W = 19;

    typedef logic [2:0] pixel_t;

    localparam pixel_t PIX_EMPTY  = 3'b000;
    localparam pixel_t PIX_P1     = 3'b100;
    localparam pixel_t PIX_P2     = 3'b010;
    localparam pixel_t PIX_P3     = 3'b011;
    localparam pixel_t PIX_P4     = 3'b110;
    localparam pixel_t PIX_BORDER = 3'b111;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_GAME
    } fb_owner_t;

    typedef struct packed {
        logic      valid;
        fb_owner_t owner;
    } rd_tag_t;

endpackage

// File: rtl/fb_arbiter_if.sv
// Requester and RAM-side signals of the frame-buffer arbiter.
// master = requesters plus RAM model, slave = the arbiter.
interface fb_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 3
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;

    logic              gl_req;
    logic              gl_we;
    logic [ADDR_W-1:0] gl_addr;
    logic [DATA_W-1:0] gl_wdata;
    logic              gl_gnt;
    logic [DATA_W-1:0] gl_rdata;
    logic              gl_rvalid;

    logic [ADDR_W-1:0] ram_address;
    logic              ram_write_enabled;
    logic [DATA_W-1:0] ram_write_data;
    logic [DATA_W-1:0] ram_read_data;

    modport master (
        output disp_req, disp_addr, gl_req, gl_we, gl_addr, gl_wdata, ram_read_data,
        input  disp_gnt, disp_rdata, disp_rvalid, gl_gnt, gl_rdata, gl_rvalid,
        input  ram_address, ram_write_enabled, ram_write_data
    );

    modport slave (
        input  disp_req, disp_addr, gl_req, gl_we, gl_addr, gl_wdata, ram_read_data,
        output disp_gnt, disp_rdata, disp_rvalid, gl_gnt, gl_rdata, gl_rvalid,
        output ram_address, ram_write_enabled, ram_write_data
    );

endinterface

// File: rtl/fb_arbiter_rd_pipe.sv
// Read-tag shift register aligned to RAM latency, steering returned data to its owner.
module fb_rd_pipe
    import fb_arbiter_pkg::*;
#(
    parameter int DATA_W      = 3,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  fb_owner_t         issue_owner,
    input  logic [DATA_W-1:0] ram_read_data,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] gl_rdata,
    output logic              gl_rvalid
);

    localparam int DEPTH = RAM_LATENCY + 1;

    rd_tag_t [DEPTH-1:0] tag_q;
    rd_tag_t             new_tag;
    rd_tag_t             ret_tag;
    logic                ret_disp;
    logic                ret_game;

    always_comb begin
        new_tag.valid = (issue_owner != OWN_NONE);
        new_tag.owner = issue_owner;
        ret_tag       = tag_q[DEPTH-1];
        ret_disp      = ret_tag.valid && (ret_tag.owner == OWN_DISP);
        ret_game      = ret_tag.valid && (ret_tag.owner == OWN_GAME);
    end

    // Oldest stage lines up with the cycle ram_read_data is valid for that command.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q <= {tag_q[DEPTH-2:0], new_tag};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_rdata  <= '0;
            disp_rvalid <= 1'b0;
            gl_rdata    <= '0;
            gl_rvalid   <= 1'b0;
        end else begin
            disp_rvalid <= ret_disp;
            gl_rvalid   <= ret_game;
            if (ret_disp) begin
                disp_rdata <= ram_read_data;
            end
            if (ret_game) begin
                gl_rdata <= ram_read_data;
            end
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer RAM arbiter: display has priority, game is granted after MAX_STARVE
// consecutive display wins while it waits.
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 3,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_STARVE  = 4
) (
    input logic         clock,
    input logic         reset,
    fb_arbiter_if.slave bus
);

    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    logic [3:0]        starve_q;
    logic [3:0]        starve_d;
    logic              game_wins;
    logic              disp_gnt;
    logic              gl_gnt;
    fb_owner_t         issue_owner;
    logic [ADDR_W-1:0] ram_address_q;
    logic              ram_we_q;
    logic [DATA_W-1:0] ram_wdata_q;

    always_comb begin
        game_wins = bus.gl_req && (!bus.disp_req || (starve_q == STARVE_MAX));
        disp_gnt  = !reset && bus.disp_req && !game_wins;
        gl_gnt    = !reset && game_wins;

        starve_d = starve_q;
        if (!bus.gl_req || gl_gnt) begin
            starve_d = '0;
        end else if (disp_gnt && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end

        issue_owner = OWN_NONE;
        if (disp_gnt) begin
            issue_owner = OWN_DISP;
        end else if (gl_gnt && !bus.gl_we) begin
            issue_owner = OWN_GAME;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Address holds across idle cycles; write data is forced to 0 unless writing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_address_q <= '0;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= '0;
        end else if (gl_gnt) begin
            ram_address_q <= bus.gl_addr;
            ram_we_q      <= bus.gl_we;
            ram_wdata_q   <= bus.gl_we ? bus.gl_wdata : '0;
        end else if (disp_gnt) begin
            ram_address_q <= bus.disp_addr;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= '0;
        end else begin
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end
    end

    assign bus.disp_gnt          = disp_gnt;
    assign bus.gl_gnt            = gl_gnt;
    assign bus.ram_address       = ram_address_q;
    assign bus.ram_write_enabled = ram_we_q;
    assign bus.ram_write_data    = ram_wdata_q;

    fb_rd_pipe #(
        .DATA_W      (DATA_W),
        .RAM_LATENCY (RAM_LATENCY)
    ) u_rd_pipe (
        .clock         (clock),
        .reset         (reset),
        .issue_owner   (issue_owner),
        .ram_read_data (bus.ram_read_data),
        .disp_rdata    (bus.disp_rdata),
        .disp_rvalid   (bus.disp_rvalid),
        .gl_rdata      (bus.gl_rdata),
        .gl_rvalid     (bus.gl_rvalid)
    );

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed scenarios plus a read-return scoreboard
// fed from observed grants and a behavioural single-port RAM.
module tb_fb_arbiter;
    import fb_arbiter_pkg::*;

    localparam int ADDR_W      = 19;
    localparam int DATA_W      = 3;
    localparam int RAM_LATENCY = 1;
    localparam int MAX_STARVE  = 4;

    typedef struct {
        fb_owner_t         owner;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    int                cyc      = 0;
    int                n_checks = 0;
    int                n_fail   = 0;
    exp_t              sb_q[$];
    logic [DATA_W-1:0] ram_mem[int];
    logic [DATA_W-1:0] sb_mem[int];

    fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .RAM_LATENCY (RAM_LATENCY),
        .MAX_STARVE  (MAX_STARVE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Single-port RAM, one cycle read latency.
    always @(posedge clock) begin : ram_model
        logic [DATA_W-1:0] v;
        int a;
        a = int'(bus.ram_address);
        v = ram_mem.exists(a) ? ram_mem[a] : '0;
        if (bus.ram_write_enabled === 1'b1) ram_mem[a] = bus.ram_write_data;
        bus.ram_read_data <= v;
    end

    function automatic logic [DATA_W-1:0] sb_rd(input logic [ADDR_W-1:0] a);
        return sb_mem.exists(int'(a)) ? sb_mem[int'(a)] : '0;
    endfunction

    always @(posedge reset) sb_q.delete();

    always @(negedge clock) begin : monitor
        exp_t e;
        logic [DATA_W-1:0] got;
        fb_owner_t who;
        if (reset === 1'b1) begin
            n_checks++;
            if ({bus.disp_gnt, bus.gl_gnt, bus.disp_rvalid, bus.gl_rvalid, bus.ram_write_enabled} !== 5'b0
                || bus.ram_address !== '0) begin
                n_fail++;
                $display("FAIL mon_reset_outputs: outputs not zero during reset (ram_address=%0d)", bus.ram_address);
            end
        end else begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                e = sb_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL sb_missing_rvalid: got no rvalid, required %s data %b at cycle %0d", e.owner.name(), e.data, e.cyc);
            end
            if (bus.disp_rvalid === 1'b1 || bus.gl_rvalid === 1'b1) begin
                n_checks++;
                who = (bus.disp_rvalid === 1'b1) ? OWN_DISP : OWN_GAME;
                got = (bus.disp_rvalid === 1'b1) ? bus.disp_rdata : bus.gl_rdata;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_rvalid: got %s rvalid data %b at cycle %0d, required none", who.name(), got, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.disp_rvalid === 1'b1 && bus.gl_rvalid === 1'b1) begin
                        n_fail++;
                        $display("FAIL sb_dual_rvalid: got both rvalids at cycle %0d, required only %s", cyc, e.owner.name());
                    end else if (who != e.owner || got !== e.data || e.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL sb_return: got %s %b at cycle %0d, required %s %b at cycle %0d",
                                 who.name(), got, cyc, e.owner.name(), e.data, e.cyc);
                    end
                end
            end
            n_checks++;
            if (bus.disp_gnt === 1'b1 && bus.gl_gnt === 1'b1) begin
                n_fail++;
                $display("FAIL mon_grant_exclusive: got both grants at cycle %0d, required at most one", cyc);
            end
            if (bus.disp_gnt === 1'b1) begin
                e.owner = OWN_DISP;
                e.data  = sb_rd(bus.disp_addr);
                e.cyc   = cyc + 2 + RAM_LATENCY;
                sb_q.push_back(e);
            end
            if (bus.gl_gnt === 1'b1) begin
                if (bus.gl_we === 1'b1) begin
                    sb_mem[int'(bus.gl_addr)] = bus.gl_wdata;
                end else begin
                    e.owner = OWN_GAME;
                    e.data  = sb_rd(bus.gl_addr);
                    e.cyc   = cyc + 2 + RAM_LATENCY;
                    sb_q.push_back(e);
                end
            end
        end
    end

    task automatic drive(input logic dr, input int da, input logic gr, input logic gw, input int ga,
                         input logic [DATA_W-1:0] gd);
        bus.disp_req  = dr;
        bus.disp_addr = ADDR_W'(da);
        bus.gl_req    = gr;
        bus.gl_we     = gw;
        bus.gl_addr   = ADDR_W'(ga);
        bus.gl_wdata  = gd;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input int a, input logic [DATA_W-1:0] v);
        ram_mem[a] = v;
        sb_mem[a]  = v;
    endtask

    task automatic idle(input int n);
        step();
        drive(1'b0, 0, 1'b0, 1'b0, 0, '0);
        repeat (n) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b0, 0, '0);
        repeat (2) @(negedge clock);
        n_checks++;
        if (bus.ram_address !== '0 || bus.ram_write_enabled !== 1'b0 || bus.ram_write_data !== '0) begin
            n_fail++;
            $display("FAIL reset_ram_pins: got addr=%0d we=%b wd=%b, required 0/0/0",
                     bus.ram_address, bus.ram_write_enabled, bus.ram_write_data);
        end
        n_checks++;
        if ({bus.disp_rvalid, bus.gl_rvalid, bus.disp_rdata, bus.gl_rdata, bus.disp_gnt, bus.gl_gnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rv=%b%b rd=%b/%b gnt=%b%b, required all 0", bus.disp_rvalid,
                     bus.gl_rvalid, bus.disp_rdata, bus.gl_rdata, bus.disp_gnt, bus.gl_gnt);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_game_write();
        step();
        drive(1'b0, 0, 1'b1, 1'b1, 38420, 3'b100);
        @(negedge clock);
        n_checks++;
        if (bus.gl_gnt !== 1'b1 || bus.disp_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL gw_grant: got gl_gnt=%b disp_gnt=%b, required 1/0", bus.gl_gnt, bus.disp_gnt);
        end
        step();
        drive(1'b0, 0, 1'b0, 1'b0, 0, '0);
        @(negedge clock);
        n_checks++;
        if (bus.ram_address !== 19'd38420 || bus.ram_write_enabled !== 1'b1 || bus.ram_write_data !== 3'b100) begin
            n_fail++;
            $display("FAIL gw_ram_cmd: got addr=%0d we=%b wd=%b, required 38420/1/100",
                     bus.ram_address, bus.ram_write_enabled, bus.ram_write_data);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clock);
            n_checks++;
            if (bus.gl_rvalid !== 1'b0 || bus.disp_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL gw_no_rvalid: got gl=%b disp=%b at idle cycle %0d, required 0/0", bus.gl_rvalid, bus.disp_rvalid, k);
            end
            if (k == 0) begin
                n_checks++;
                if (bus.ram_address !== 19'd38420 || bus.ram_write_enabled !== 1'b0 || bus.ram_write_data !== '0) begin
                    n_fail++;
                    $display("FAIL gw_idle_hold: got addr=%0d we=%b wd=%b, required 38420/0/000",
                             bus.ram_address, bus.ram_write_enabled, bus.ram_write_data);
                end
            end
        end
    endtask

    task automatic test_disp_read();
        preload(100, 3'b111);
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) drive(1'b1, 100, 1'b0, 1'b0, 0, '0);
            else        drive(1'b0, 0, 1'b0, 1'b0, 0, '0);
            @(negedge clock);
            if (k == 0) begin
                n_checks++;
                if (bus.disp_gnt !== 1'b1 || bus.gl_gnt !== 1'b0) begin
                    n_fail++;
                    $display("FAIL dr_grant: got disp_gnt=%b gl_gnt=%b, required 1/0", bus.disp_gnt, bus.gl_gnt);
                end
            end
            if (k == 1) begin
                n_checks++;
                if (bus.ram_address !== 19'd100 || bus.ram_write_enabled !== 1'b0) begin
                    n_fail++;
                    $display("FAIL dr_ram_cmd: got addr=%0d we=%b, required 100/0", bus.ram_address, bus.ram_write_enabled);
                end
            end
            n_checks++;
            if (bus.disp_rvalid !== (k == 3) || bus.gl_rvalid !== 1'b0 || (k == 3 && bus.disp_rdata !== 3'b111)) begin
                n_fail++;
                $display("FAIL dr_return: cycle %0d got disp_rvalid=%b data=%b gl_rvalid=%b, required %b/111/0",
                         k, bus.disp_rvalid, bus.disp_rdata, bus.gl_rvalid, (k == 3));
            end
        end
    endtask

    task automatic test_contention();
        logic exp_gl;
        for (int k = 0; k < 15; k++) begin
            step();
            drive(1'b1, 5, 1'b1, 1'b0, 6, '0);
            @(negedge clock);
            exp_gl = ((k % (MAX_STARVE + 1)) == MAX_STARVE);
            n_checks++;
            if (bus.gl_gnt !== exp_gl || bus.disp_gnt !== !exp_gl) begin
                n_fail++;
                $display("FAIL contention: cycle %0d got disp_gnt=%b gl_gnt=%b, required %b/%b",
                         k, bus.disp_gnt, bus.gl_gnt, !exp_gl, exp_gl);
            end
        end
        idle(6);
    endtask

    task automatic test_interleave();
        for (int k = 0; k < 7; k++) begin
            step();
            case (k)
                0:       drive(1'b1, 5, 1'b0, 1'b0, 0, '0);
                1:       drive(1'b0, 0, 1'b1, 1'b0, 6, '0);
                2:       drive(1'b1, 7, 1'b0, 1'b0, 0, '0);
                default: drive(1'b0, 0, 1'b0, 1'b0, 0, '0);
            endcase
            @(negedge clock);
            n_checks++;
            if (bus.disp_rvalid !== (k == 3 || k == 5) || bus.gl_rvalid !== (k == 4)
                || (k == 3 && bus.disp_rdata !== 3'b001) || (k == 4 && bus.gl_rdata !== 3'b010)
                || (k == 5 && bus.disp_rdata !== 3'b011)) begin
                n_fail++;
                $display("FAIL interleave: cycle %0d got disp %b/%b gl %b/%b, required disp_rvalid=%b gl_rvalid=%b",
                         k, bus.disp_rvalid, bus.disp_rdata, bus.gl_rvalid, bus.gl_rdata, (k == 3 || k == 5), (k == 4));
            end
        end
    endtask

    task automatic test_back_to_back();
        preload(200, 3'b001);
        for (int k = 0; k < 7; k++) begin
            step();
            case (k)
                0:       drive(1'b0, 0, 1'b1, 1'b1, 200, 3'b110);
                1:       drive(1'b0, 0, 1'b1, 1'b0, 200, '0);
                2:       drive(1'b1, 200, 1'b0, 1'b0, 0, '0);
                default: drive(1'b0, 0, 1'b0, 1'b0, 0, '0);
            endcase
            @(negedge clock);
            if (k == 4) begin
                n_checks++;
                if (bus.gl_rvalid !== 1'b1 || bus.gl_rdata !== 3'b110) begin
                    n_fail++;
                    $display("FAIL raw_game: got gl_rvalid=%b data=%b, required 1/110", bus.gl_rvalid, bus.gl_rdata);
                end
            end
            if (k == 5) begin
                n_checks++;
                if (bus.disp_rvalid !== 1'b1 || bus.disp_rdata !== 3'b110) begin
                    n_fail++;
                    $display("FAIL raw_disp: got disp_rvalid=%b data=%b, required 1/110", bus.disp_rvalid, bus.disp_rdata);
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        for (int k = 0; k < 7; k++) begin
            step();
            case (k)
                0: drive(1'b1, 5, 1'b0, 1'b0, 0, '0);
                1: drive(1'b0, 0, 1'b1, 1'b0, 6, '0);
                2: begin
                    reset = 1'b1;
                    drive(1'b1, 7, 1'b0, 1'b0, 0, '0);
                    #1;
                    n_checks++;
                    if (bus.ram_address !== '0 || bus.disp_gnt !== 1'b0 || bus.gl_gnt !== 1'b0
                        || bus.disp_rdata !== '0 || bus.gl_rdata !== '0) begin
                        n_fail++;
                        $display("FAIL rst_async: got addr=%0d gnt=%b%b rdata=%b/%b, required all 0",
                                 bus.ram_address, bus.disp_gnt, bus.gl_gnt, bus.disp_rdata, bus.gl_rdata);
                    end
                    #1;
                    reset = 1'b0;
                end
                default: drive(1'b0, 0, 1'b0, 1'b0, 0, '0);
            endcase
            @(negedge clock);
            if (k == 2) begin
                n_checks++;
                if (bus.disp_gnt !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rst_first_grant: got disp_gnt=%b, required 1", bus.disp_gnt);
                end
            end
            if (k == 3) begin
                n_checks++;
                if (bus.ram_address !== 19'd7) begin
                    n_fail++;
                    $display("FAIL rst_ram_cmd: got addr=%0d, required 7", bus.ram_address);
                end
            end
            if (k >= 3) begin
                n_checks++;
                if (bus.gl_rvalid !== 1'b0 || bus.disp_rvalid !== (k == 5) || (k == 5 && bus.disp_rdata !== 3'b011)) begin
                    n_fail++;
                    $display("FAIL rst_return: cycle %0d got disp %b/%b gl_rvalid=%b, required disp_rvalid=%b data 011 gl 0",
                             k, bus.disp_rvalid, bus.disp_rdata, bus.gl_rvalid, (k == 5));
                end
            end
        end
    endtask

    task automatic test_starve_clear();
        for (int k = 0; k < 9; k++) begin
            step();
            drive(1'b1, 5, (k != 3), 1'b0, 6, '0);
            @(negedge clock);
            n_checks++;
            if (bus.gl_gnt !== (k == 8) || bus.disp_gnt !== (k != 8)) begin
                n_fail++;
                $display("FAIL starve_clear: cycle %0d got disp_gnt=%b gl_gnt=%b, required %b/%b",
                         k, bus.disp_gnt, bus.gl_gnt, (k != 8), (k == 8));
            end
        end
        idle(6);
    endtask

    initial begin
        test_reset();
        preload(5, 3'b001);
        preload(6, 3'b010);
        preload(7, 3'b011);
        test_game_write();
        test_disp_read();
        idle(2);
        test_contention();
        test_interleave();
        idle(2);
        test_back_to_back();
        idle(2);
        test_reset_inflight();
        idle(2);
        test_starve_clear();
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) step();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d outstanding reads, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares the single-port 320x240x3 frame-buffer RAM between two requesters:
  - the VGA scan-out reader (display port, read-only, latency-sensitive);
  - game_logic (game port, read/write).
- Display has fixed priority, with a bounded-starvation guarantee for the game port.
- Sits between both requesters and the RAM; owns the RAM address/write pins exclusively.

Parameters:
- ADDR_W, 19, frame-buffer address width.
- DATA_W, 3, pixel width.
- RAM_LATENCY, 1, cycles from address on RAM pins to valid ram_read_data (>=1).
- MAX_STARVE, 4, consecutive display grants tolerated while game waits (1..15).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- disp_req  in  1  display read request; held with disp_addr until granted.
- disp_addr  in  ADDR_W  display read address.
- disp_gnt  out  1  display request accepted this cycle (combinational).
- disp_rdata  out  DATA_W  display read data.
- disp_rvalid  out  1  disp_rdata valid (one-cycle pulse per accepted read).
- gl_req  in  1  game request; held with gl_we/gl_addr/gl_wdata until granted.
- gl_we  in  1  1 = write, 0 = read.
- gl_addr  in  ADDR_W  game address.
- gl_wdata  in  DATA_W  game write data.
- gl_gnt  out  1  game request accepted this cycle (combinational).
- gl_rdata  out  DATA_W  game read data.
- gl_rvalid  out  1  gl_rdata valid (reads only).
- ram_address  out  ADDR_W  registered RAM address.
- ram_write_enabled  out  1  registered RAM write enable.
- ram_write_data  out  DATA_W  registered RAM write data.
- ram_read_data  in  DATA_W  RAM read data.

Behaviour:
- Reset:
  - all outputs 0;
  - starve counter 0;
  - read pipeline cleared; in-flight reads are discarded and never produce rvalid.
- Grant decision, cycle N:
  - At most one of disp_gnt/gl_gnt is high.
  - Display only → disp_gnt.
  - Game only → gl_gnt.
  - Both, and starve < MAX_STARVE → disp_gnt.
  - Both, and starve == MAX_STARVE → gl_gnt.
- Starve counter (4 bits):
  - +1 on each cycle gl_req=1 and disp_gnt=1;
  - cleared on gl_gnt, or on any cycle with gl_req=0;
  - saturates at MAX_STARVE.
- RAM command: in cycle N+1, ram_address/ram_write_enabled/ram_write_data carry the granted request.
  - ram_write_enabled=1 only for a granted game write.
  - ram_write_data is 0 on reads and idle cycles.
- Idle cycle (no grant): ram_write_enabled=0; ram_address holds its last value.
- Read return:
  - A read tag (valid, owner) is shifted through a RAM_LATENCY+1 deep pipeline.
  - ram_read_data is registered into the owner's rdata; the owner's rvalid is asserted in cycle N+2+RAM_LATENCY. Default is N+3.
  - The non-owner's rvalid stays 0; its rdata holds its previous value.
  - Full throughput: one accepted request per cycle, any owner mix; returns arrive in grant order.
- Writes produce no rvalid.
- Ordering: commands are serialized at the RAM, so a read granted after a write to the same address returns the new data.
- Reset mid-operation: outputs go to 0 asynchronously. The first grant is possible on the first clock edge after reset deasserts.
- A requester dropping req without a grant is legal; no state is kept for it.

Decomposition:
- tron_types package additions:
  - FB_WIDTH=320, FB_HEIGHT=240, FB_ADDR_W=19;
  - typedef pixel_t (logic [2:0]);
  - colour constants: PIX_EMPTY 000, PIX_P1 100, PIX_P2 010, PIX_P3 011, PIX_P4 110, PIX_BORDER 111;
  - enum fb_owner_t {OWN_NONE, OWN_DISP, OWN_GAME}.
- Sub-module fb_rd_pipe: parameterised tag shift register plus return-data demux.

Test Plan:
- Game-only write: gl_req=1, gl_we=1, gl_addr=38420, gl_wdata=100 at cycle 0 → gl_gnt=1 in cycle 0; in cycle 1, ram_address=38420, ram_write_enabled=1, ram_write_data=100; no rvalid ever.
- Display read: disp_req=1, disp_addr=100, RAM model returns 111 → disp_gnt cycle 0, ram_address=100 cycle 1, disp_rvalid=1 with disp_rdata=111 in cycle 3 only; gl_rvalid=0 throughout.
- Contention, MAX_STARVE=4: both requesters assert continuously → grant sequence D,D,D,D,G repeats; gl_gnt exactly every 5th cycle.
- Interleaved reads: grants D(addr 5), G(addr 6), D(addr 7) back-to-back, RAM returns 001/010/011 → disp_rvalid cycles 3 and 5 with 001 and 011; gl_rvalid cycle 4 with 010.
- Reset with two reads in flight (reset at cycle 2) → all outputs 0 immediately; no rvalid after deassert; new read accepted on first edge after deassert.
- Starve counter clear: 3 display grants while gl waits, gl_req low 1 cycle, then reasserted with disp_req held → 4 further display grants before gl_gnt.
